// File: rtl/button_command_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_command_controller_pkg
//  Description : Shared FSM state type, command codes and hold-counter width
//                for the button command controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_command_controller_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_ABORT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_LONG  = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/button_command_controller_press_timer.sv
`default_nettype none
// ============================================================================
//  Module      : press_timer
//  Description : Saturating hold counter with minimum / long-press threshold
//                flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module press_timer
    import button_command_controller_pkg::*;
#(
    parameter int MIN_PRESS_CYCLES  = 4,
    parameter int LONG_PRESS_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             reached_min,
    output logic             reached_long
);

    localparam logic [CNT_W-1:0] c_MIN_CNT  = CNT_W'(MIN_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] c_LONG_CNT = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_SAT_CNT  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // Count held cycles; stick at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_SAT_CNT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count        = r_count;
    assign reached_min  = (r_count >= c_MIN_CNT);
    assign reached_long = (r_count >= c_LONG_CNT);

endmodule
`default_nettype wire

// File: rtl/button_command_controller.sv
`default_nettype none
// ============================================================================
//  Module      : button_command_controller
//  Description : Classifies debounced button presses into START (short press,
//                reader idle) or ABORT (long press, reader busy) commands and
//                offers them over a valid/ready handshake; illegal combinations
//                produce a one-cycle drop pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_command_controller
    import button_command_controller_pkg::*;
#(
    parameter int MIN_PRESS_CYCLES  = 4,
    parameter int LONG_PRESS_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       debounced_line,
    input  logic       reader_busy,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic       cmd_dropped
);

    state_t           r_state;
    logic             r_line_q;
    logic             r_armed;
    logic             r_cmd_valid;
    logic [1:0]       r_cmd_code;
    logic             r_cmd_dropped;

    logic             w_press_edge;
    logic             w_release_edge;
    logic             w_timer_clear;
    logic             w_timer_enable;
    logic [CNT_W-1:0] w_hold_count;
    logic             w_reached_min;
    logic             w_reached_long;

    // Line history plus an arm flag: r_line_q resets to 1, so a button held
    // through reset would otherwise look like a fresh press. The arm flag
    // only sets once the line has been seen released.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_q <= 1'b1;
            r_armed  <= 1'b0;
        end else begin
            r_line_q <= debounced_line;
            if (debounced_line) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_press_edge   = r_line_q & ~debounced_line & r_armed;
    assign w_release_edge = ~r_line_q & debounced_line;

    // Counter is held at zero while idle so a press always starts from 0;
    // the clear only fires when there is something left to clear.
    assign w_timer_clear  = (r_state == ST_IDLE) && (w_hold_count != '0);
    assign w_timer_enable = ((r_state == ST_PRESS) || (r_state == ST_LONG))
                            && !debounced_line;

    press_timer #(
        .MIN_PRESS_CYCLES  (MIN_PRESS_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .clear        (w_timer_clear),
        .enable       (w_timer_enable),
        .count        (w_hold_count),
        .reached_min  (w_reached_min),
        .reached_long (w_reached_long)
    );

    // Press classification FSM with registered command / drop outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cmd_valid   <= 1'b0;
            r_cmd_code    <= CMD_NONE;
            r_cmd_dropped <= 1'b0;
        end else begin
            r_cmd_dropped <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_press_edge) begin
                        r_state <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    // A release takes priority over the long threshold.
                    if (w_release_edge) begin
                        if (!w_reached_min) begin
                            r_state <= ST_IDLE;
                        end else if (!reader_busy) begin
                            r_state     <= ST_ISSUE;
                            r_cmd_valid <= 1'b1;
                            r_cmd_code  <= CMD_START;
                        end else begin
                            r_state       <= ST_IDLE;
                            r_cmd_dropped <= 1'b1;
                        end
                    end else if (w_reached_long) begin
                        r_state <= ST_LONG;
                    end
                end
                ST_LONG: begin
                    if (w_release_edge) begin
                        if (reader_busy) begin
                            r_state     <= ST_ISSUE;
                            r_cmd_valid <= 1'b1;
                            r_cmd_code  <= CMD_ABORT;
                        end else begin
                            r_state       <= ST_IDLE;
                            r_cmd_dropped <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        r_state     <= ST_IDLE;
                        r_cmd_valid <= 1'b0;
                        r_cmd_code  <= CMD_NONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_valid <= 1'b0;
                    r_cmd_code  <= CMD_NONE;
                end
            endcase
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_code    = r_cmd_code;
    assign cmd_dropped = r_cmd_dropped;

endmodule
`default_nettype wire

// File: tb/tb_button_command_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_command_controller
//  Description : Scoreboard bench for button_command_controller. Each press
//                pushes its expected command or drop; a monitor pops and
//                compares when the DUT produces output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_command_controller;
    import button_command_controller_pkg::*;

    localparam int c_MIN  = 4;
    localparam int c_LONG = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       debounced_line = 1'b1;
    logic       reader_busy = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       cmd_dropped;

    typedef struct {
        logic [1:0] code;
        int         due;
        int         len;
    } exp_cmd_t;

    exp_cmd_t cmd_q[$];
    int       drop_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    button_command_controller #(
        .MIN_PRESS_CYCLES  (c_MIN),
        .LONG_PRESS_CYCLES (c_LONG)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .debounced_line (debounced_line),
        .reader_busy    (reader_busy),
        .cmd_ready      (cmd_ready),
        .cmd_valid      (cmd_valid),
        .cmd_code       (cmd_code),
        .cmd_dropped    (cmd_dropped)
    );

    always #5 clk = ~clk;

    // Cycle stamp: after posedge N the value is N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on command rise / drop pulse.
    logic     r_prev_valid = 1'b0;
    logic     r_prev_drop  = 1'b0;
    int       vlen = 0;
    int       exp_len = 1;
    logic [1:0] held_code = CMD_NONE;
    always @(negedge clk) begin
        exp_cmd_t e;
        if (!cmd_valid) chk("code_when_not_valid", cmd_code, CMD_NONE);
        if (cmd_dropped) chk("drop_with_valid_rise", cmd_valid & ~r_prev_valid, 0);
        if (r_prev_drop) chk("drop_width", cmd_dropped, 0);
        if (cmd_dropped && !r_prev_drop) begin
            if (drop_q.size() == 0) chk("unexpected_drop", cmd_dropped, 0);
            else                    chk("drop_cycle", cyc, drop_q.pop_front());
        end
        if (cmd_valid && !r_prev_valid) begin
            if (cmd_q.size() == 0) begin
                chk("unexpected_cmd", cmd_valid, 0);
                exp_len   = 1;
                held_code = cmd_code;
            end else begin
                e = cmd_q.pop_front();
                chk("cmd_code", cmd_code, e.code);
                chk("cmd_latency", cyc, e.due);
                exp_len   = e.len;
                held_code = e.code;
            end
            vlen = 1;
        end else if (cmd_valid) begin
            vlen++;
            chk("code_stable", cmd_code, held_code);
        end else if (r_prev_valid) begin
            chk("valid_length", vlen, exp_len);
        end
        r_prev_valid = cmd_valid;
        r_prev_drop  = cmd_dropped;
    end

    // Hold the line low for n cycles, release, predict the outcome, then
    // pulse cmd_ready rdy_delay cycles after cmd_valid would rise.
    task automatic press(input int n, input logic busy, input int rdy_delay);
        int   held;
        logic is_long;
        exp_cmd_t e;
        reader_busy    = busy;
        debounced_line = 0;
        repeat (n) step();
        // First low cycle is the press edge; each later low cycle counts.
        held = n - 1;
        chk("hold_count", dut.u_timer.count, (held > 65535) ? 65535 : held);
        debounced_line = 1;
        // Counter must pass LONG-1 while still held to become a long press.
        is_long = (held >= c_LONG);
        if (held >= c_MIN) begin
            if (is_long == busy) begin
                e.code = is_long ? CMD_ABORT : CMD_START;
                e.due  = cyc + 1;
                e.len  = rdy_delay + 1;
                cmd_q.push_back(e);
            end else begin
                drop_q.push_back(cyc + 1);
            end
        end
        repeat (rdy_delay + 1) step();
        cmd_ready = 1;
        step();
        cmd_ready = 0;
        repeat (3) step();
        reader_busy = 0;
        chk("state_idle", dut.r_state, ST_IDLE);
    endtask

    initial begin
        exp_cmd_t e;
        repeat (3) step();
        reset = 0;
        step();
        chk("rst_valid", cmd_valid, 0);
        chk("rst_code", cmd_code, CMD_NONE);
        chk("rst_drop", cmd_dropped, 0);
        chk("rst_state", dut.r_state, ST_IDLE);

        // Glitch, short START with stalled ready, long ABORT.
        press(2, 0, 0);
        press(20, 0, 5);
        press(150, 1, 0);
        // Two dropped presses.
        press(20, 1, 0);
        press(150, 0, 0);

        // Reset in the middle of a long hold: nothing may come out of it.
        reader_busy    = 0;
        debounced_line = 0;
        repeat (50) step();
        reset = 1;
        step();
        reset = 0;
        chk("midrst_valid", cmd_valid, 0);
        chk("midrst_code", cmd_code, CMD_NONE);
        chk("midrst_drop", cmd_dropped, 0);
        chk("midrst_state", dut.r_state, ST_IDLE);
        repeat (99) step();
        debounced_line = 1;
        repeat (2) step();
        cmd_ready = 1;
        step();
        cmd_ready = 0;
        repeat (3) step();
        chk("midrst_after_release", dut.r_state, ST_IDLE);
        press(20, 0, 0);

        // Press during ISSUE and keep holding into IDLE: must be ignored.
        reader_busy    = 0;
        debounced_line = 0;
        repeat (20) step();
        debounced_line = 1;
        e.code = CMD_START;
        e.due  = cyc + 1;
        e.len  = 4;
        cmd_q.push_back(e);
        step();
        debounced_line = 0;
        repeat (3) step();
        cmd_ready = 1;
        step();
        cmd_ready = 0;
        repeat (10) step();
        chk("held_into_idle", dut.r_state, ST_IDLE);
        debounced_line = 1;
        repeat (5) step();

        // Saturation of the hold counter.
        press(70000, 1, 2);

        repeat (5) step();
        chk("cmd_q_empty", cmd_q.size(), 0);
        chk("drop_q_empty", drop_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
